// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared image geometry and streamer state type for the conv datapath
// Purpose: constants shared by the pixel streamer and the conv block, plus the
//          streamer FSM state enum.
// Ports:   none (package)
package cnn_pkg;

   localparam int IMG_W      = 28;
   localparam int IMG_H      = 28;
   localparam int PIX_W      = 8;
   localparam int IMG_PIXELS = IMG_W * IMG_H;
   // Must cover IMG_PIXELS entries: 2**ADDR_W >= IMG_PIXELS.
   localparam int ADDR_W     = 10;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } streamer_state_t;

endpackage

// File: rtl/img_buffer.sv
// rtl/img_buffer.sv - one-write/one-read image RAM with registered, read-before-write output
// Purpose: holds one image; shaped so synthesis can map it onto block RAM.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset (clears the read register only)
//   i_wr_en    write strobe
//   i_wr_addr  write address; addresses >= DEPTH are dropped
//   i_wr_data  write data
//   i_rd_en    load the read register from i_rd_addr
//   i_rd_addr  read address
//   o_rd_data  registered read data
module img_buffer
   import cnn_pkg::*;
#(
   parameter int DEPTH = IMG_PIXELS,
   parameter int AW    = ADDR_W,
   parameter int DW    = PIX_W
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);

   logic [DW-1:0] r_mem [0:DEPTH-1];
   logic [DW-1:0] r_rd_data;
   logic          w_wr_in_range;

   // One extra bit keeps the compare exact even when DEPTH == 2**AW.
   assign w_wr_in_range = ({1'b0, i_wr_addr} < (AW+1)'(DEPTH));

   // Storage has no reset so it stays RAM-mappable and survives a stream abort.
   always_ff @(posedge i_clk) begin
      if (i_wr_en && w_wr_in_range) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Reading the array with non-blocking update gives old data on an
   // address collision with a same-edge write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - streams a buffered image in raster order into the conv pixel input
// Purpose: loads one image through a write port; on i_start emits it one pixel per
//          clock with raster position, frame markers and completion status.
// Ports:
//   i_clk, i_rst                      clock / synchronous active-high reset
//   i_wr_en, i_wr_addr, i_wr_data     buffer write port (accepted in every state)
//   i_start                           begin one frame (honoured in IDLE only)
//   i_hold                            stall the stream while high
//   o_pixel_out, o_pixel_valid        pixel to conv and its qualifier
//   o_pix_index, o_pix_row, o_pix_col raster position of o_pixel_out
//   o_frame_first, o_frame_last       marks pixel 0 / last pixel
//   o_busy, o_done                    frame in progress / one-cycle end pulse
module pixel_streamer
   import cnn_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [PIX_W-1:0]  i_wr_data,
   input  logic              i_start,
   input  logic              i_hold,
   output logic [PIX_W-1:0]  o_pixel_out,
   output logic              o_pixel_valid,
   output logic [15:0]       o_pix_index,
   output logic [4:0]        o_pix_row,
   output logic [4:0]        o_pix_col,
   output logic              o_frame_first,
   output logic              o_frame_last,
   output logic              o_busy,
   output logic              o_done
);

   streamer_state_t   r_state;
   logic [ADDR_W-1:0] r_ptr;      // next raster index to fetch
   logic [ADDR_W-1:0] r_index;    // raster index currently presented
   logic [4:0]        r_row;
   logic [4:0]        r_col;
   logic              r_valid;
   logic              r_first;
   logic              r_last;
   logic              r_busy;
   logic              r_done;

   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;

   // The RAM output register is the pixel output register, so the fetch has
   // to be issued on exactly the edges where the FSM advances the stream.
   always_comb begin
      w_rd_en   = 1'b0;
      w_rd_addr = r_ptr;
      case (r_state)
         IDLE: begin
            w_rd_en   = i_start;
            w_rd_addr = '0;
         end
         STREAM: w_rd_en = !i_hold && !r_last;
         default: w_rd_en = 1'b0;
      endcase
   end

   img_buffer u_img_buffer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (o_pixel_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_index <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= STREAM;
                  r_ptr   <= ADDR_W'(1);
                  r_index <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_valid <= 1'b1;
                  r_first <= 1'b1;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            STREAM: begin
               if (r_last) begin
                  // Last pixel has been shown; the frame closes regardless of hold.
                  r_state <= DONE;
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (i_hold) begin
                  r_valid <= 1'b0;
               end else begin
                  r_valid <= 1'b1;
                  r_index <= r_ptr;
                  r_ptr   <= r_ptr + 1'b1;
                  r_first <= 1'b0;
                  r_last  <= (r_ptr == ADDR_W'(IMG_PIXELS - 1));
                  if (r_col == 5'(IMG_W - 1)) begin
                     r_col <= '0;
                     r_row <= r_row + 5'd1;
                  end else begin
                     r_col <= r_col + 5'd1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_pixel_valid = r_valid;
   assign o_pix_index   = 16'(r_index);
   assign o_pix_row     = r_row;
   assign o_pix_col     = r_col;
   assign o_frame_first = r_first;
   assign o_frame_last  = r_last;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
Transmit side of the convolution engine's pixel input. Holds one 28x28 8-bit image in an internal buffer, loaded through a simple write port. On a one-cycle start pulse it streams the image in raster order, one pixel per clock, into the conv block's pixel_in. Cycle alignment matches what conv expects: pixel 0 is presented in the cycle after start is sampled. Raster position, frame markers and completion status are provided for the downstream consumer.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
PIX_W, 8, pixel width in bits
ADDR_W, 10, buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  buffer write strobe
wr_addr  in  ADDR_W  buffer write address, raster index
wr_data  in  PIX_W  buffer write data
start  in  1  begin streaming one frame; sampled on a clock edge
hold  in  1  stall: freezes the stream while high
pixel_out  out  PIX_W  current pixel, goes to conv pixel_in
pixel_valid  out  1  pixel_out carries a new pixel this cycle
pix_index  out  16  raster index of pixel_out (0..783)
pix_row  out  5  row of pixel_out
pix_col  out  5  column of pixel_out
frame_first  out  1  high with pixel index 0
frame_last  out  1  high with pixel index IMG_W*IMG_H-1
busy  out  1  streaming in progress
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Buffer contents are not cleared. Reset mid-stream aborts the frame immediately; no done pulse is produced.
- Buffer: IMG_W*IMG_H entries of PIX_W bits.
  - A write with wr_en=1 and wr_addr < IMG_W*IMG_H updates the entry at the clock edge.
  - Writes with wr_addr out of range are ignored.
  - Writes are accepted in every state.
  - A write and a read to the same address in the same cycle return the old data (read-before-write).
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - start=1 at edge k: pixel_out <= mem[0], pixel_valid <= 1, pix_index/row/col <= 0, frame_first <= 1, busy <= 1. Go to STREAM.
  - The read pointer moves to 1.
  - Latency from start sample to first valid pixel is 1 cycle.
- STREAM, hold=0: each edge loads the next pixel in raster order and advances the pointer.
  - Col wraps from IMG_W-1 to 0 with row+1.
  - frame_first is high only with index 0.
- STREAM, hold=1 at an edge: pixel_valid <= 0. pixel_out, index, row and col keep their values; the pointer does not advance.
  - On the first edge with hold=0, the stream resumes with the next unsent pixel, never repeating or skipping one.
- Last pixel (index 783): presented with frame_last=1.
  - On the next edge (hold ignored): pixel_valid <= 0, frame_last <= 0, done <= 1, busy <= 0. Go to DONE.
- DONE: lasts one cycle, then done <= 0 and the FSM returns to IDLE.
  - A start during DONE is ignored.
  - A start sampled in IDLE on the following edge begins a new frame.
- start while in STREAM is ignored; the frame in progress is not restarted.
- If start and hold are both high in IDLE, the frame starts normally and hold is only honoured from STREAM on.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Unbroken frame: pixel_valid is high for exactly 784 consecutive cycles; done follows 785 cycles after the start edge.
- pix_index is zero-extended to 16 bits.

Decomposition:
- Shared package cnn_pkg holds:
  - IMG_W/IMG_H/PIX_W constants, shared with conv.
  - IMG_PIXELS = IMG_W*IMG_H.
  - The streamer state enum {IDLE, STREAM, DONE}.
- One sub-module, img_buffer: simple dual-port RAM with one write port and a registered read port, read-before-write. This lets the buffer infer block RAM.
- Raster counters and the FSM live in pixel_streamer.

Test Plan:
- Load mem[i]=i mod 256, pulse start at cycle 0, hold=0 → pixel_out=0, valid=1 and frame_first=1 at cycle 1. Pixel 783 (value 15) appears at cycle 784 with frame_last=1, row=27, col=27. done=1 only at cycle 785; valid is high for exactly 784 cycles.
- Raster wrap → at index 27, row=0/col=27; at index 28, row=1/col=0.
- hold=1 for 3 cycles while index 100 is presented → valid=0 for those 3 cycles, then index 101 follows. done shifts by 3 cycles; no pixel is repeated or lost.
- Second start pulse at index 50 → ignored, stream continues to 783. Writing wr_addr=900 → no buffer change.
- rst=1 at index 400 → all outputs 0 the next cycle, no done pulse. A following start streams from index 0 with the original buffer data intact.
- During a stream, write wr_addr=500, wr_data=0xAA in the cycle index 500 is read → the old value is streamed. The next frame streams 0xAA at index 500.
